// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store request, validates funct3,
// alignment and address range, performs a single-cycle RAM access and returns
// an extended load result or an error code through a valid/ready response.
//
// Ports:
//   clk, resetn                 rising-edge clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          store/load select and access size/sign
//   req_addr, req_wdata         byte address and right-aligned store data
//   resp_valid/resp_ready       response handshake
//   resp_rdata, resp_err        extended load data, error code
//   mem_wr_*, mem_by_wlen       RAM write port (active in EXEC only)
//   mem_rd_*, mem_by_rlen       RAM read port (active in EXEC only)
//   mem_rd_data                 combinational RAM read data
module load_store_unit #(
  parameter logic [31:0] START_ADDRESS = 32'd0,
  parameter logic [31:0] STOP_ADDRESS  = 32'd1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_wr_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_by_wlen,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_en,
  output logic [1:0]  mem_by_rlen,
  input  logic [31:0] mem_rd_data
);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_RANGE   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic [1:0]  len_c;
  logic        illegal_c;
  logic        misaligned_c;
  logic        out_of_range_c;
  logic [32:0] last_c;
  logic [1:0]  err_c;
  logic [31:0] ext_c;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid)  state_d = S_EXEC;
      S_EXEC:                  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Request decode; len_c doubles as (size - 1) for the range check
  always_comb begin
    case (f3_q[1:0])
      2'b01:   len_c = 2'b01;
      2'b10:   len_c = 2'b11;
      default: len_c = 2'b00;
    endcase
    if (we_q) illegal_c = f3_q[2] || (f3_q[1:0] == 2'b11);
    else      illegal_c = (f3_q[1:0] == 2'b11) || (f3_q[2] && f3_q[1]);
    misaligned_c = ((len_c == 2'b01) && addr_q[0]) ||
                   ((len_c == 2'b11) && (addr_q[1:0] != 2'b00));
    // 33-bit sum so that an access wrapping past 0xFFFFFFFF is out of range
    last_c = {1'b0, addr_q} + 33'(len_c);
    out_of_range_c = (addr_q < START_ADDRESS) || (last_c > {1'b0, STOP_ADDRESS});
    if (illegal_c)           err_c = ERR_ILLEGAL;
    else if (misaligned_c)   err_c = ERR_ALIGN;
    else if (out_of_range_c) err_c = ERR_RANGE;
    else                     err_c = ERR_OK;
  end

  // Load data extension
  always_comb begin
    case (f3_q)
      3'b000:  ext_c = {{24{mem_rd_data[7]}}, mem_rd_data[7:0]};
      3'b001:  ext_c = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
      3'b100:  ext_c = {24'd0, mem_rd_data[7:0]};
      3'b101:  ext_c = {16'd0, mem_rd_data[15:0]};
      default: ext_c = mem_rd_data;
    endcase
  end

  // Output decode; memory strobes follow state so reset drops them at once
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_wr_addr = 32'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 32'd0;
    mem_by_wlen = 2'b00;
    mem_rd_addr = 32'd0;
    mem_rd_en   = 1'b0;
    mem_by_rlen = 2'b00;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_EXEC: begin
        if (err_c == ERR_OK) begin
          if (we_q) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = addr_q;
            mem_wr_data = wdata_q;
            mem_by_wlen = len_c;
          end else begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = addr_q;
            mem_by_rlen = len_c;
          end
        end
      end
      S_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Request capture in IDLE, result capture at the end of EXEC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= ERR_OK;
    end else begin
      if ((state_q == S_IDLE) && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_EXEC) begin
        err_q   <= err_c;
        rdata_q <= (!we_q && (err_c == ERR_OK)) ? ext_c : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 1 KiB byte-addressed RAM model.
module tb_load_store_unit;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_wr_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_by_wlen;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_en;
  logic [1:0]  mem_by_rlen;
  logic [31:0] mem_rd_data;

  int chk_cnt;
  int pass_cnt;

  logic [7:0] mem [0:1023];

  load_store_unit #(.START_ADDRESS(32'd0), .STOP_ADDRESS(32'd1023)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_by_wlen(mem_by_wlen),
    .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_by_rlen(mem_by_rlen),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: little-endian, length code 00/01/11 = 1/2/4 bytes
  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if ((i <= int'(mem_by_wlen)) && ((mem_wr_addr + 32'(i)) < 32'd1024))
          mem[mem_wr_addr + 32'(i)] <= mem_wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_rd_data = 32'd0;
    if (mem_rd_en) begin
      for (int i = 0; i < 4; i++) begin
        if ((i <= int'(mem_by_rlen)) && ((mem_rd_addr + 32'(i)) < 32'd1024))
          mem_rd_data[8*i +: 8] = mem[mem_rd_addr + 32'(i)];
      end
    end
  end

  // One complete transaction with resp_ready=1; returns result and observations
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic [1:0] er,
                        output int lat, output int wrs, output int rds, output logic [1:0] wl);
    lat = 1; wrs = 0; rds = 0; wl = 2'b00; rd = 32'd0; er = 2'b00;
    @(negedge clk);
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b want 1", req_ready);
    else pass_cnt++;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!resp_valid && lat < 8) begin
      if (mem_wr_en) begin wrs++; wl = mem_by_wlen; end
      if (mem_rd_en) rds++;
      lat++;
      @(posedge clk); #1;
    end
    rd = resp_rdata;
    er = resp_err;
    if (!resp_valid) lat = 99;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    chk_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else pass_cnt++;
    chk_cnt++;
    if (resp_rdata !== 32'd0 || resp_err !== 2'b00)
      $display("FAIL rst_resp_data: got %h/%b want 0/00", resp_rdata, resp_err);
    else pass_cnt++;
    chk_cnt++;
    if ({mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data, mem_rd_addr, mem_by_wlen, mem_by_rlen} !== '0)
      $display("FAIL rst_mem_outputs: got wr_en=%b rd_en=%b want all 0", mem_wr_en, mem_rd_en);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic [1:0] er, wl; int lat, wrs, rds;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (wrs != 1 || rds != 0 || wl !== 2'b11)
      $display("FAIL sw_pulse: got wr=%0d rd=%0d wlen=%b want 1 0 11", wrs, rds, wl);
    else pass_cnt++;
    chk_cnt++;
    if (er !== 2'b00 || rd !== 32'd0 || lat != 2)
      $display("FAIL sw_resp: got err=%b rdata=%h lat=%0d want 00 0 2", er, rd, lat);
    else pass_cnt++;
    chk_cnt++;
    if ({mem[19], mem[18], mem[17], mem[16]} !== 32'hDEADBEEF)
      $display("FAIL sw_mem: got %h want deadbeef", {mem[19], mem[18], mem[17], mem[16]});
    else pass_cnt++;
    do_req(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (rd !== 32'hDEADBEEF || er !== 2'b00 || lat != 2 || rds != 1 || wrs != 0)
      $display("FAIL lw_resp: got rdata=%h err=%b lat=%0d rd=%0d wr=%0d want deadbeef 00 2 1 0",
               rd, er, lat, rds, wrs);
    else pass_cnt++;
  endtask

  task automatic test_extension();
    logic [31:0] rd; logic [1:0] er, wl; int lat, wrs, rds;
    do_req(1'b1, 3'b000, 32'h21, 32'h00000080, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (wl !== 2'b00 || wrs != 1) $display("FAIL sb_wlen: got %b/%0d want 00/1", wl, wrs); else pass_cnt++;
    do_req(1'b1, 3'b000, 32'h22, 32'h00000034, rd, er, lat, wrs, rds, wl);
    do_req(1'b1, 3'b000, 32'h23, 32'h000000F2, rd, er, lat, wrs, rds, wl);
    do_req(1'b0, 3'b000, 32'h21, 32'd0, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (rd !== 32'hFFFFFF80 || er !== 2'b00) $display("FAIL lb: got %h/%b want ffffff80/00", rd, er); else pass_cnt++;
    do_req(1'b0, 3'b100, 32'h21, 32'd0, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (rd !== 32'h00000080 || er !== 2'b00) $display("FAIL lbu: got %h/%b want 00000080/00", rd, er); else pass_cnt++;
    do_req(1'b0, 3'b001, 32'h22, 32'd0, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (rd !== 32'hFFFFF234 || er !== 2'b00) $display("FAIL lh: got %h/%b want fffff234/00", rd, er); else pass_cnt++;
    do_req(1'b0, 3'b101, 32'h22, 32'd0, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (rd !== 32'h0000F234 || er !== 2'b00) $display("FAIL lhu: got %h/%b want 0000f234/00", rd, er); else pass_cnt++;
    do_req(1'b1, 3'b001, 32'h24, 32'hAAAA1357, rd, er, lat, wrs, rds, wl);
    chk_cnt++;
    if (wl !== 2'b01 || {mem[37], mem[36]} !== 16'h1357 || mem[38] !== 8'h00)
      $display("FAIL sh: got wlen=%b data=%h want 01 1357", wl, {mem[37], mem[36]});
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic [1:0] er, wl; int lat, wrs, rds;
    logic        v_we  [10];
    logic [2:0]  v_f3  [10];
    logic [31:0] v_a   [10];
    logic [1:0]  v_err [10];
    v_we = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v_f3 = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b000, 3'b010, 3'b011, 3'b110, 3'b000, 3'b010};
    v_a  = '{32'h13, 32'h401, 32'h3FE, 32'h3FF, 32'h400, 32'hFFFFFFFC, 32'h10, 32'h10,
             32'h3FF, 32'h3FC};
    v_err = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 10; i++) begin
      do_req(v_we[i], v_f3[i], v_a[i], 32'h12345678, rd, er, lat, wrs, rds, wl);
      chk_cnt++;
      if (er !== v_err[i] || lat != 2)
        $display("FAIL err_code[%0d]: got err=%b lat=%0d want %b 2", i, er, lat, v_err[i]);
      else pass_cnt++;
      if (v_err[i] != 2'b00) begin
        chk_cnt++;
        if (rd !== 32'd0 || wrs != 0 || rds != 0)
          $display("FAIL err_side[%0d]: got rdata=%h wr=%0d rd=%0d want 0 0 0", i, rd, wrs, rds);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if ({mem[1023], mem[1022]} !== 16'h0000)
      $display("FAIL err_mem: got %h want 0000", {mem[1023], mem[1022]});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 8) begin @(posedge clk); #1; n++; end
    chk_cnt++;
    if (resp_valid !== 1'b1 || n != 1)
      $display("FAIL bp_resp: got valid=%b wait=%0d want 1 1", resp_valid, n);
    else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      chk_cnt++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 2'b00 ||
          req_ready !== 1'b0 || mem_wr_en !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b rdy=%b wen=%b want 1 deadbeef 00 0 0",
                 c, resp_valid, resp_rdata, resp_err, req_ready, mem_wr_en);
      else pass_cnt++;
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_release: got v=%b rdy=%b want 0 1", resp_valid, req_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({mem[51], mem[50], mem[49], mem[48]} !== 32'd0)
      $display("FAIL bp_ignored: got %h want 0", {mem[51], mem[50], mem[49], mem[48]});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h21; req_wdata = 32'd0;
    @(posedge clk); t0 = int'($time);
    #1;
    t1 = 0;
    for (int c = 0; c < 8 && t1 == 0; c++) begin
      @(posedge clk);
      if (req_ready === 1'b1) t1 = int'($time);
    end
    #1;
    req_valid = 1'b0;
    chk_cnt++;
    if (t1 - t0 != 30) $display("FAIL b2b_interval: got %0d ns want 30", t1 - t0); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000080)
      $display("FAIL b2b_second: got v=%b d=%h want 1 00000080", resp_valid, resp_rdata);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic [1:0] er, wl; int lat, wrs, rds;
    do_req(1'b1, 3'b000, 32'h40, 32'h00000011, rd, er, lat, wrs, rds, wl);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h40; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_cnt++;
    if (mem_wr_en !== 1'b1) $display("FAIL abort_exec: got wr_en=%b want 1", mem_wr_en); else pass_cnt++;
    #1 resetn = 1'b0;
    #1;
    chk_cnt++;
    if (mem_wr_en !== 1'b0 || mem_wr_addr !== 32'd0)
      $display("FAIL abort_async: got wr_en=%b addr=%h want 0 0", mem_wr_en, mem_wr_addr);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL abort_after[%0d]: got v=%b rdy=%b want 0 1", c, resp_valid, req_ready);
      else pass_cnt++;
    end
    chk_cnt++;
    if (mem[64] !== 8'h11) $display("FAIL abort_mem: got %h want 11", mem[64]); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_extension();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter START_ADDRESS, default 0, meaning the lowest valid data byte address, inclusive.
REQ-002 The block SHALL have parameter STOP_ADDRESS, default 1023, meaning the highest valid data byte address, inclusive.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RV32I funct3 (access size and sign).
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_rdata  output  32  load result after extension.
REQ-015 resp_err  output  2  00 ok, 01 illegal funct3, 10 misaligned, 11 out of range.
REQ-016 mem_wr_addr, mem_wr_en, mem_wr_data, mem_by_wlen  output  32/1/32/2  RAM write port.
REQ-017 mem_rd_addr, mem_rd_en, mem_by_rlen  output  32/1/2  RAM read port.
REQ-018 mem_rd_data  input  32  RAM combinational read data, unused bytes zero.

Function
REQ-019 The block SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-020 In IDLE the block SHALL drive req_ready=1; in every other state it SHALL drive req_ready=0.
REQ-021 On a clock edge in IDLE with req_valid=1, the block SHALL register req_we, req_funct3, req_addr and req_wdata and move to EXEC.
REQ-022 EXEC SHALL last exactly one cycle and then move to RESP.
REQ-023 In RESP the block SHALL hold resp_valid=1 with stable resp_rdata and resp_err until an edge with resp_ready=1, then move to IDLE.
REQ-024 The response SHALL appear with resp_valid=1 in the second cycle after acceptance; the minimum request-to-request interval SHALL be 3 cycles.
REQ-025 Legal loads SHALL be funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be 000 SB, 001 SH and 010 SW; every other code SHALL be illegal.
REQ-026 An access SHALL be misaligned when it is a half-word with addr[0]=1, or a word with addr[1:0]!=00.
REQ-027 An access SHALL be out of range when addr<START_ADDRESS or addr+size-1>STOP_ADDRESS; this check SHALL be computed in 33 bits so that wrap-around counts as out of range.
REQ-028 Error priority SHALL be illegal, then misaligned, then out of range.
REQ-029 A request with any error SHALL assert neither mem_wr_en nor mem_rd_en.
REQ-030 For a legal store, the block SHALL assert mem_wr_en during the EXEC cycle only, with mem_wr_addr=addr, mem_wr_data=wdata and mem_by_wlen=00/01/11 for byte/half/word.
REQ-031 For a legal load, the block SHALL assert mem_rd_en during EXEC only, with mem_rd_addr=addr and mem_by_rlen=00/01/11, and SHALL capture the extended mem_rd_data at the end of EXEC.
REQ-032 Load extension SHALL be: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend, LW passes all 32 bits.
REQ-033 resp_rdata SHALL be 0 for stores and for any error response.
REQ-034 Whenever the corresponding enable is 0, all mem_* address, data and length outputs SHALL be 0.
REQ-035 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-036 While resetn=0, the state SHALL be IDLE; req_ready SHALL be 1 once reset is released; resp_valid, resp_rdata, resp_err and all mem_* outputs SHALL be 0.
REQ-037 Reset asserted in EXEC SHALL drop mem_wr_en/mem_rd_en immediately, without waiting for a clock edge; no response SHALL be produced for the aborted request.

Verification
REQ-038 The bench SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> one write pulse with by_wlen=11; load resp_rdata=0xDEADBEEF, resp_err=00, resp_valid in cycle 2.
REQ-039 The bench SHALL cover: memory byte 0x80 at addr 0x21; LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; with bytes 0x34,0xF2 at 0x22/0x23, LH 0x22 -> 0xFFFFF234.
REQ-040 The bench SHALL cover: LW 0x13 -> resp_err=10; SH 0x401 with STOP_ADDRESS=1023 -> resp_err=10; SW 0x3FE -> resp_err=10, no memory enable in any case.
REQ-041 The bench SHALL cover: LH 0x3FF -> resp_err=10; LB 0x400 -> resp_err=11; SW 0xFFFFFFFC -> resp_err=11; store funct3=011 -> resp_err=01; resp_rdata=0 in every case.
REQ-042 The bench SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0 throughout, new req_valid ignored; resp_ready=1 -> IDLE next cycle.
REQ-043 The bench SHALL cover: resetn pulsed low mid-EXEC of SB -> mem_wr_en falls asynchronously, target byte unchanged, no resp_valid, req_ready=1 after release.
